// File: rtl/bcd_ctrl_pkg.sv
// Shared types and constants for the BCD count sequencer.
package bcd_ctrl_pkg;

  localparam int DIGIT_W = 4;
  localparam logic [DIGIT_W-1:0] BCD_MAX = 4'd9;
  localparam logic [DIGIT_W-1:0] BCD_MIN = 4'd0;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2,
    DONE = 2'd3
  } state_t;

  // True when a nibble holds a legal decimal digit.
  function automatic logic bcd_legal(input logic [DIGIT_W-1:0] nib);
    return (nib <= BCD_MAX);
  endfunction

endpackage

// File: rtl/bcd_digit_step.sv
// Single BCD digit increment/decrement cell; cells ripple carry/borrow
// from the least significant digit upwards.
module bcd_digit_step
  import bcd_ctrl_pkg::*;
(
  input  logic [DIGIT_W-1:0] digit,
  input  logic               dir,
  input  logic               cin,
  output logic [DIGIT_W-1:0] digit_nxt,
  output logic               cout
);

  // Step the digit only when a carry/borrow arrives; >=9 wraps on the way up
  // so that illegal nibbles still roll over to 0.
  always_comb begin
    digit_nxt = digit;
    cout      = 1'b0;
    if (cin) begin
      if (dir) begin
        if (digit >= BCD_MAX) begin
          digit_nxt = BCD_MIN;
          cout      = 1'b1;
        end else begin
          digit_nxt = digit + 4'd1;
        end
      end else begin
        if (digit == BCD_MIN) begin
          digit_nxt = BCD_MAX;
          cout      = 1'b1;
        end else begin
          digit_nxt = digit - 4'd1;
        end
      end
    end
  end

endmodule

// File: rtl/bcd_seq_ctrl.sv
// Command-driven BCD up/down sequencer: loads a start value, steps it at a
// prescaled rate until it equals the target, then pulses done.
// Optional build macro BCD_CHECK_EN rejects commands carrying non-BCD nibbles
// and pulses err; without it err stays 0 and no check is made.
module bcd_seq_ctrl
  import bcd_ctrl_pkg::*;
#(
  parameter int DIGITS   = 4,
  parameter int TICK_DIV = 1
) (
  input  logic                  clk,
  input  logic                  clr,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_dir,
  input  logic [4*DIGITS-1:0]   cmd_start,
  input  logic [4*DIGITS-1:0]   cmd_target,
  input  logic                  abort,
  output logic [4*DIGITS-1:0]   count,
  output logic                  busy,
  output logic                  done,
  output logic                  err
);

  localparam int CW = DIGIT_W * DIGITS;
  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] PRE_LAST = PW'(TICK_DIV - 1);

  state_t          state;
  logic [PW-1:0]   presc;
  logic            dir_q;
  logic [CW-1:0]   target_q;
  logic [CW-1:0]   count_step;
  logic [DIGITS:0] carry;
  logic            cmd_fire;
  logic            cmd_illegal;

  assign cmd_ready = (state == IDLE);
  assign busy      = (state != IDLE);
  assign cmd_fire  = cmd_valid & cmd_ready;

  // Ripple chain: digit 0 always receives the step request.
  assign carry[0] = 1'b1;

  for (genvar d = 0; d < DIGITS; d++) begin : g_digit
    bcd_digit_step u_step (
      .digit     (count[d*DIGIT_W +: DIGIT_W]),
      .dir       (dir_q),
      .cin       (carry[d]),
      .digit_nxt (count_step[d*DIGIT_W +: DIGIT_W]),
      .cout      (carry[d+1])
    );
  end

`ifdef BCD_CHECK_EN
  // Flag a command if any start or target nibble is outside 0..9.
  always_comb begin
    cmd_illegal = 1'b0;
    for (int d = 0; d < DIGITS; d++) begin
      if (!bcd_legal(cmd_start[d*DIGIT_W +: DIGIT_W]) ||
          !bcd_legal(cmd_target[d*DIGIT_W +: DIGIT_W]))
        cmd_illegal = 1'b1;
    end
  end
`else
  assign cmd_illegal = 1'b0;
`endif

  // Sequencer FSM owning the count register, prescaler and latched command.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state    <= IDLE;
      count    <= '0;
      presc    <= '0;
      dir_q    <= 1'b0;
      target_q <= '0;
      done     <= 1'b0;
      err      <= 1'b0;
    end else begin
      done <= 1'b0;
      err  <= 1'b0;
      case (state)
        IDLE: begin
          if (cmd_fire) begin
            if (cmd_illegal) begin
              err <= 1'b1;
            end else begin
              dir_q    <= cmd_dir;
              target_q <= cmd_target;
              count    <= cmd_start;
              state    <= LOAD;
            end
          end
        end
        LOAD: begin
          presc <= '0;
          state <= abort ? IDLE : RUN;
        end
        RUN: begin
          if (abort) begin
            state <= IDLE;
          end else if (count == target_q) begin
            state <= DONE;
            done  <= 1'b1;
          end else if (presc == PRE_LAST) begin
            count <= count_step;
            presc <= '0;
          end else begin
            presc <= presc + PW'(1);
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
